// File: rtl/selen_run_ctrl_if.sv
// Status/handshake bundle between selen_run_ctrl and the core/bench it sequences.
// master = sequencer side, slave = observer side.
interface selen_run_ctrl_if;
    logic        cache_ready;
    logic        core_rst_n;
    logic        running;
    logic        done;
    logic        fail;
    logic [2:0]  state;
    logic [31:0] cycles;

    modport master (
        input  cache_ready,
        output core_rst_n,
        output running,
        output done,
        output fail,
        output state,
        output cycles
    );

    modport slave (
        output cache_ready,
        input  core_rst_n,
        input  running,
        input  done,
        input  fail,
        input  state,
        input  cycles
    );
endinterface

// File: rtl/selen_run_ctrl.sv
// Reset-and-run sequencer for selen_top: holds the core in reset, waits for the
// L1I cache, times a fixed run window and latches a sticky pass/fail status.
module selen_run_ctrl #(
    parameter int unsigned RST_CYCLES    = 5,
    parameter int unsigned READY_TIMEOUT = 1024,
    parameter int unsigned RUN_CYCLES    = 100,
    parameter int unsigned CNT_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    selen_run_ctrl_if.master   bus
);

    localparam int unsigned CYC_W = 32;

    // Terminal counts compared against the phase counter before it increments
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(READY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_MAX  = '1;

    typedef enum logic [2:0] {
        ST_RESET      = 3'd0,
        ST_WAIT_READY = 3'd1,
        ST_RUN        = 3'd2,
        ST_DONE       = 3'd3,
        ST_FAIL       = 3'd4
    } state_t;

    state_t             st;
    logic [CNT_W-1:0]   cnt;
    logic [CYC_W-1:0]   cyc;
    logic               core_rst_n_q;
    logic               running_q;
    logic               done_q;
    logic               fail_q;

    // Sequencer: state, phase counter, elapsed-cycle counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            st           <= ST_RESET;
            cnt          <= '0;
            cyc          <= '0;
            core_rst_n_q <= 1'b0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            case (st)
                ST_RESET: begin
                    if (cnt == RST_LAST) begin
                        st           <= ST_WAIT_READY;
                        cnt          <= '0;
                        core_rst_n_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_WAIT_READY: begin
                    if (cyc != CYC_MAX) cyc <= cyc + CYC_W'(1);
                    // Ready takes precedence over a timeout on the same edge
                    if (bus.cache_ready) begin
                        st        <= ST_RUN;
                        cnt       <= '0;
                        running_q <= 1'b1;
                    end else if (cnt == TO_LAST) begin
                        st     <= ST_FAIL;
                        cnt    <= '0;
                        fail_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_RUN: begin
                    if (cyc != CYC_MAX) cyc <= cyc + CYC_W'(1);
                    if (cnt == RUN_LAST) begin
                        st        <= ST_DONE;
                        cnt       <= '0;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_DONE, ST_FAIL: begin
                    // Terminal: everything holds until rst
                end

                default: begin
                    st           <= ST_RESET;
                    cnt          <= '0;
                    cyc          <= '0;
                    core_rst_n_q <= 1'b0;
                    running_q    <= 1'b0;
                    done_q       <= 1'b0;
                    fail_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state      = 3'(st);
    assign bus.cycles     = cyc;
    assign bus.core_rst_n = core_rst_n_q;
    assign bus.running    = running_q;
    assign bus.done       = done_q;
    assign bus.fail       = fail_q;

    a_done_fail_excl: assert property (@(posedge clk) !(done_q && fail_q));

endmodule

// File: tb/tb_selen_run_ctrl.sv
// Directed bench for selen_run_ctrl: a nominal instance (5/16/100) and a
// minimum-parameter instance (1/1/1), with hand-computed expectations.
module tb_selen_run_ctrl;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_checks = 0;
    int   n_fail   = 0;

    selen_run_ctrl_if bus_a();
    selen_run_ctrl_if bus_b();

    selen_run_ctrl #(
        .RST_CYCLES    (5),
        .READY_TIMEOUT (16),
        .RUN_CYCLES    (100),
        .CNT_W         (16)
    ) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    selen_run_ctrl #(
        .RST_CYCLES    (1),
        .READY_TIMEOUT (1),
        .RUN_CYCLES    (1),
        .CNT_W         (16)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;

        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.cache_ready = 1'b0;
        bus_b.cache_ready = 1'b1;

        // ---------------- nominal pass ----------------
        repeat (3) tick();
        check("rst_state",   32'(bus_a.state),   0);
        check("rst_corerst", 32'(bus_a.core_rst_n), 0);
        check("rst_running", 32'(bus_a.running), 0);
        check("rst_done",    32'(bus_a.done),    0);
        check("rst_fail",    32'(bus_a.fail),    0);
        check("rst_cycles",  bus_a.cycles,       0);

        rst_a = 1'b0;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            n++;
            if (bus_a.core_rst_n) break;
        end
        check("nom_rst_len", 32'(n), 5);
        check("nom_wait_state", 32'(bus_a.state), 1);

        repeat (10) tick();
        check("nom_still_wait", 32'(bus_a.state), 1);
        bus_a.cache_ready = 1'b1;
        tick();
        check("nom_run_state", 32'(bus_a.state), 2);
        check("nom_run_flag",  32'(bus_a.running), 1);

        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (!bus_a.running) break;
            n++;
            tick();
        end
        check("nom_run_len", 32'(n), 100);
        check("nom_done",    32'(bus_a.done),  1);
        check("nom_fail",    32'(bus_a.fail),  0);
        check("nom_state",   32'(bus_a.state), 3);
        check("nom_cycles",  bus_a.cycles,     111);

        // ---------------- terminal hold ----------------
        for (int i = 0; i < 50; i++) begin
            bus_a.cache_ready = ~bus_a.cache_ready;
            tick();
            check("hold_state",  32'(bus_a.state), 3);
            check("hold_done",   32'(bus_a.done),  1);
            check("hold_cycles", bus_a.cycles,     111);
        end

        // ---------------- reset mid-run ----------------
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        bus_a.cache_ready = 1'b1;
        repeat (6) tick();
        check("mid_run_entry", 32'(bus_a.state), 2);
        repeat (50) tick();
        check("mid_run_cycles", bus_a.cycles, 51);
        rst_a = 1'b1;
        tick();
        check("mid_rst_state",   32'(bus_a.state),      0);
        check("mid_rst_corerst", 32'(bus_a.core_rst_n), 0);
        check("mid_rst_running", 32'(bus_a.running),    0);
        check("mid_rst_cycles",  bus_a.cycles,          0);
        check("mid_rst_done",    32'(bus_a.done),       0);
        rst_a = 1'b0;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            n++;
            if (bus_a.done) break;
        end
        check("mid_redo_len",    32'(n),            106);
        check("mid_redo_done",   32'(bus_a.done),   1);
        check("mid_redo_cycles", bus_a.cycles,      101);

        // ---------------- timeout ----------------
        bus_a.cache_ready = 1'b0;
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        repeat (5) tick();
        check("to_wait_state", 32'(bus_a.state), 1);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            n++;
            if (bus_a.fail) break;
        end
        check("to_len",     32'(n),                16);
        check("to_state",   32'(bus_a.state),      4);
        check("to_done",    32'(bus_a.done),       0);
        check("to_corerst", 32'(bus_a.core_rst_n), 1);
        check("to_cycles",  bus_a.cycles,          16);
        repeat (10) tick();
        check("to_frozen_cycles", bus_a.cycles,     16);
        check("to_frozen_state",  32'(bus_a.state), 4);
        check("to_frozen_fail",   32'(bus_a.fail),  1);

        // ---------------- ready/timeout collision ----------------
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        repeat (5) tick();
        repeat (15) tick();
        check("col_pre_state", 32'(bus_a.state), 1);
        bus_a.cache_ready = 1'b1;
        tick();
        check("col_state",   32'(bus_a.state),   2);
        check("col_fail",    32'(bus_a.fail),    0);
        check("col_running", 32'(bus_a.running), 1);
        check("col_cycles",  bus_a.cycles,       16);

        // ---------------- minimum parameters ----------------
        check("min_rst_state", 32'(bus_b.state), 0);
        rst_b = 1'b0;
        tick();
        check("min_e0_state",   32'(bus_b.state),      1);
        check("min_e0_corerst", 32'(bus_b.core_rst_n), 1);
        tick();
        check("min_e1_state",   32'(bus_b.state),   2);
        check("min_e1_running", 32'(bus_b.running), 1);
        tick();
        check("min_e2_state",   32'(bus_b.state),   3);
        check("min_e2_done",    32'(bus_b.done),    1);
        check("min_e2_running", 32'(bus_b.running), 0);
        check("min_e2_cycles",  bus_b.cycles,       2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/selen_run_ctrl.md
# selen_run_ctrl

Synthesizable reset-and-run sequencer that sits directly upstream of `selen_top`. It takes the system clock and a raw synchronous reset, drives the core's active-low `rst_n`, and waits for the L1 instruction cache to report `cache_ready`. It then times a fixed run window and reports a terminal pass (`done`) or fail (`fail`) status to the bench or to board-level logic.

## Interface
Parameters:
- `RST_CYCLES`, 5: number of cycles `core_rst_n` is held low after `rst` is sampled low; must be ≥1.
- `READY_TIMEOUT`, 1024: maximum number of cycles to wait for `cache_ready`; must be ≥1.
- `RUN_CYCLES`, 100: number of cycles the core runs after ready before `done`; must be ≥1.
- `CNT_W`, 16: phase-counter width; each of the three cycle parameters must be ≤ 2^CNT_W.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cache_ready`  in  1  L1I cache ready, from `cpu_cluster.l1_cache.l1i.cache_ready`.
- `core_rst_n`  out  1  active-low reset to `selen_top.rst_n`.
- `running`  out  1  high while in RUN.
- `done`  out  1  sticky pass flag.
- `fail`  out  1  sticky ready-timeout flag.
- `state`  out  3  current FSM state encoding, for debug.
- `cycles`  out  32  cycles elapsed since `core_rst_n` was released.

## Operation
- The FSM has five states, encoded as RESET=0, WAIT_READY=1, RUN=2, DONE=3, FAIL=4.
- `cnt` is a CNT_W-bit phase counter. It clears to 0 on every state transition.
- RESET:
  - `core_rst_n`=0.
  - Each edge with `rst`=0 increments `cnt`.
  - When `cnt`==RST_CYCLES-1, go to WAIT_READY.
- WAIT_READY:
  - `core_rst_n`=1.
  - If `cache_ready`=1 at the edge, go to RUN.
  - Otherwise, if `cnt`==READY_TIMEOUT-1, go to FAIL.
  - Otherwise increment `cnt`.
  - If both conditions hold on the same edge, ready wins and the FSM goes to RUN.
- RUN:
  - `running`=1.
  - Increment `cnt`; when `cnt`==RUN_CYCLES-1, go to DONE.
  - If `cache_ready` deasserts during RUN, it is ignored.
- DONE and FAIL:
  - Both are terminal; only `rst` leaves them.
  - `core_rst_n` stays 1 in both.
  - `done`=1 in DONE; `fail`=1 in FAIL.
- `cycles` counter:
  - Increments by 1 on every edge in WAIT_READY and RUN.
  - Saturates at 0xFFFF_FFFF; it does not wrap.
  - Frozen in DONE and FAIL.
- `done` and `fail` are never 1 at the same time.

## Timing
- All outputs are registered; none has a combinational path from an input.
- Reset (`rst`=1 sampled at an edge): after that edge, state=RESET, `cnt`=0, `cycles`=0, `core_rst_n`=0, `running`=0, `done`=0, `fail`=0.
- Reset applies from any state, including mid-RUN and from DONE/FAIL.
- Reset has priority over every other transition.
- `core_rst_n` release:
  - With `rst` low from edge E0 onward, `core_rst_n` rises after edge E0+RST_CYCLES-1.
  - With RST_CYCLES=5 and `rst` sampled low at E0, `core_rst_n` rises after edge E4.
- Ready latency:
  - `cache_ready` high at edge E gives state=RUN and `running`=1 after E, i.e. one cycle latency.
  - If `cache_ready` is already high on the first WAIT_READY edge, RUN is entered after that edge.
- RUN length: `running` is high for exactly RUN_CYCLES cycles, then `done` rises and `running` falls on the same edge.
- Timeout: with `cache_ready` held low, `fail` rises READY_TIMEOUT cycles after WAIT_READY is entered.
- `cycles` at DONE equals (WAIT_READY cycles) + RUN_CYCLES.
- Parameter value 1 is legal for all three cycle parameters and gives a single-cycle phase.

## Test plan
- Nominal pass:
  - Stimulus: RST_CYCLES=5, RUN_CYCLES=100; `rst`=1 for 3 cycles; `cache_ready` rises 10 cycles after `core_rst_n` rises.
  - Required: `core_rst_n` low for 5 cycles after `rst` falls; `running` high for 100 cycles; `done`=1; `fail`=0; `cycles`=111.
- Timeout:
  - Stimulus: READY_TIMEOUT=16; `cache_ready` held 0.
  - Required: `fail`=1 exactly 16 cycles after WAIT_READY entry; state=4; `done`=0; `core_rst_n` stays 1; `cycles` frozen at 16.
- Ready/timeout collision:
  - Stimulus: READY_TIMEOUT=16; `cache_ready` rises on the 16th WAIT_READY edge.
  - Required: state goes to RUN (2); `fail` stays 0.
- Reset mid-run:
  - Stimulus: assert `rst` for 1 cycle at RUN cycle 50.
  - Required: the next cycle shows state=0, `core_rst_n`=0, `running`=0, `cycles`=0; the full sequence then repeats and ends with `done`=1.
- Terminal hold:
  - Stimulus: after `done`, toggle `cache_ready` for 50 cycles.
  - Required: state stays 3; `done` stays 1; `cycles` is unchanged.
- Minimum parameters:
  - Stimulus: RST_CYCLES=1, READY_TIMEOUT=1, RUN_CYCLES=1; `cache_ready` tied 1.
  - Required: RESET, WAIT_READY and RUN each last 1 cycle; `done`=1 three edges after `rst` is sampled low; `cycles`=2.
